if_stage: RTL and testbench

- Instruction-fetch stage; sits directly upstream of the decode stage.
- Owns the 8-bit program counter and drives a ready-handshaked instruction-memory port.
- Registers each fetched instruction together with its PC into the IF/ID pipeline register, which decode consumes.
- Handles downstream stalls using a one-entry skid buffer, and handles taken-jump redirects by flushing.

---
 rtl/if_stage_if.sv | 21 ++
 rtl/if_stage.sv | 91 +++++++++
 tb/tb_if_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory fetch port between if_stage and imem
interface if_stage_if;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_ready;
   logic [7:0] imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_data
   );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, imem request, IF/ID register with one-entry skid
module if_stage #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter logic [7:0] NOP_INST = 8'h00
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              stall,
   input  logic              jump,
   input  logic [7:0]        jumpTarget,
   if_stage_if.master        imem,
   output logic [7:0]        inst,
   output logic [7:0]        PCout,
   output logic              valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] pc;
   logic [7:0] skid_inst;
   logic [7:0] skid_pc;
   logic       skid_full;
   logic       accepted;

   // The request is decoded straight off the state register so reset kills it at once.
   assign imem.imem_req  = (state == FETCH);
   assign imem.imem_addr = pc;
   assign accepted       = (state == FETCH) && imem.imem_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         inst      <= NOP_INST;
         PCout     <= RESET_PC;
         valid     <= 1'b0;
         skid_inst <= NOP_INST;
         skid_pc   <= RESET_PC;
         skid_full <= 1'b0;
      end else if (jump) begin
         // Redirect drops anything fetched this cycle and any parked skid entry.
         state     <= FETCH;
         pc        <= jumpTarget;
         inst      <= NOP_INST;
         PCout     <= jumpTarget;
         valid     <= 1'b0;
         skid_full <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= FETCH;
            end
            FETCH: begin
               if (accepted && !stall) begin
                  inst  <= imem.imem_data;
                  PCout <= pc;
                  valid <= 1'b1;
                  pc    <= pc + 8'd1;
               end else if (accepted) begin
                  skid_inst <= imem.imem_data;
                  skid_pc   <= pc;
                  skid_full <= 1'b1;
                  pc        <= pc + 8'd1;
                  state     <= HOLD;
               end else if (!stall) begin
                  inst  <= NOP_INST;
                  valid <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  inst      <= skid_inst;
                  PCout     <= skid_pc;
                  valid     <= skid_full;
                  skid_full <= 1'b0;
                  state     <= FETCH;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;
   logic       clock = 1'b0;
   logic       reset_n;
   logic       stall;
   logic       jump;
   logic [7:0] jumpTarget;
   logic [7:0] inst;
   logic [7:0] PCout;
   logic       valid;
   int         n_tests = 0;
   int         n_fail  = 0;

   if_stage_if mif ();

   if_stage #(.RESET_PC(8'h00), .NOP_INST(8'h00)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .stall      (stall),
      .jump       (jump),
      .jumpTarget (jumpTarget),
      .imem       (mif.master),
      .inst       (inst),
      .PCout      (PCout),
      .valid      (valid)
   );

   always #5 clock = ~clock;

   // Memory returns addr + 0x10 for whatever address is presented.
   always_comb mif.imem_data = mif.imem_addr + 8'h10;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [7:0] e_inst, input logic [7:0] e_pc, input logic e_valid);
      check({tag, ".inst"},  inst,  e_inst);
      check({tag, ".pcout"}, PCout, e_pc);
      check({tag, ".valid"}, {7'd0, valid}, {7'd0, e_valid});
   endtask

   task automatic chk_req(input string tag, input logic e_req, input logic [7:0] e_addr);
      check({tag, ".req"},  {7'd0, mif.imem_req}, {7'd0, e_req});
      if (e_req) check({tag, ".addr"}, mif.imem_addr, e_addr);
   endtask

   initial begin
      reset_n = 1'b0; stall = 1'b0; jump = 1'b0; jumpTarget = 8'h00;
      mif.imem_ready = 1'b1;
      tick(); tick();
      chk_ifid("rst", 8'h00, 8'h00, 1'b0);
      chk_req("rst", 1'b0, 8'h00);
      check("rst.addr", mif.imem_addr, 8'h00);

      reset_n = 1'b1;
      tick();
      chk_req("idle2fetch", 1'b1, 8'h00);
      check("idle2fetch.valid", {7'd0, valid}, 8'h00);
      tick(); chk_ifid("f0", 8'h10, 8'h00, 1'b1);
      tick(); chk_ifid("f1", 8'h11, 8'h01, 1'b1);
      tick(); chk_ifid("f2", 8'h12, 8'h02, 1'b1);
      chk_req("f2", 1'b1, 8'h03);

      // ready 0 then 1: one bubble, PCout held
      mif.imem_ready = 1'b0;
      tick(); chk_ifid("bubble", 8'h00, 8'h02, 1'b0);
      chk_req("bubble", 1'b1, 8'h03);
      mif.imem_ready = 1'b1;
      tick(); chk_ifid("f3", 8'h13, 8'h03, 1'b1);
      tick(); chk_ifid("f4", 8'h14, 8'h04, 1'b1);

      // stall while PC=05 is accepted
      stall = 1'b1;
      tick(); chk_ifid("hold0", 8'h14, 8'h04, 1'b1);
      chk_req("hold0", 1'b0, 8'h00);
      tick(); chk_ifid("hold1", 8'h14, 8'h04, 1'b1);
      tick(); chk_ifid("hold2", 8'h14, 8'h04, 1'b1);
      chk_req("hold2", 1'b0, 8'h00);
      stall = 1'b0;
      tick(); chk_ifid("unskid", 8'h15, 8'h05, 1'b1);
      chk_req("unskid", 1'b1, 8'h06);
      tick(); chk_ifid("f6", 8'h16, 8'h06, 1'b1);

      // jump together with stall and an accepted fetch
      jump = 1'b1; jumpTarget = 8'h40; stall = 1'b1;
      tick(); chk_ifid("jmp", 8'h00, 8'h40, 1'b0);
      chk_req("jmp", 1'b1, 8'h40);
      jump = 1'b0; stall = 1'b0;
      tick(); chk_ifid("f40", 8'h50, 8'h40, 1'b1);

      // park 0x41 in the skid, then jump from HOLD to 0xFE; skid must not reappear
      stall = 1'b1;
      tick(); chk_req("hold41", 1'b0, 8'h00);
      jump = 1'b1; jumpTarget = 8'hFE;
      tick(); chk_ifid("jmpfe", 8'h00, 8'hFE, 1'b0);
      chk_req("jmpfe", 1'b1, 8'hFE);
      jump = 1'b0; stall = 1'b0;
      tick(); chk_ifid("ffe", 8'h0E, 8'hFE, 1'b1);
      tick(); chk_ifid("fff", 8'h0F, 8'hFF, 1'b1);
      tick(); chk_ifid("wrap", 8'h10, 8'h00, 1'b1);
      chk_req("wrap", 1'b1, 8'h01);

      // asynchronous reset in the middle of HOLD
      stall = 1'b1;
      tick(); chk_req("hold01", 1'b0, 8'h00);
      chk_ifid("hold01", 8'h10, 8'h00, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk_ifid("arst", 8'h00, 8'h00, 1'b0);
      chk_req("arst", 1'b0, 8'h00);
      check("arst.addr", mif.imem_addr, 8'h00);
      tick();
      reset_n = 1'b1; stall = 1'b0;
      tick(); chk_req("restart", 1'b1, 8'h00);
      check("restart.valid", {7'd0, valid}, 8'h00);
      tick(); chk_ifid("restart_f0", 8'h10, 8'h00, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
